// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier: one multiplier bit per clock, WIDTH-cycle latency.
// Two's-complement mode subtracts the last partial product, which gives an exact signed result.
module seq_multiplier #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_next;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   count;
    logic            last_bit;
    logic            a_sign;

    assign a_sign = (SIGNED != 0) ? a[WIDTH-1] : 1'b0;

    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so its partial product is subtracted.
    always_comb begin
        last_bit = (count == LAST);
        addend   = '0;
        if (mplier[0]) begin
            if ((SIGNED != 0) && last_bit)
                addend = ~mcand + PW'(1);
            else
                addend = mcand;
        end
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            acc    <= '0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{a_sign}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // p is only written here, so the accumulator's partial sums never reach the output.
                    if (last_bit) begin
                        p     <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: an unsigned and a signed 4-bit instance share one stimulus stream.
// A protocol model predicts busy/done every cycle; products are queued at acceptance and popped at done.
module tb_seq_multiplier;

    localparam int W = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        logic [2*W-1:0] pu;
        logic [2*W-1:0] ps;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy_u, done_u, busy_s, done_s;
    logic [2*W-1:0] p_u, p_s;

    exp_t           sb[$];
    int             m_state = M_IDLE;
    int             m_cnt = 0;
    logic [2*W-1:0] held_u = '0;
    logic [2*W-1:0] held_s = '0;
    int             vectors = 0;
    int             miscompares = 0;

    seq_multiplier #(.WIDTH(W), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .p(p_u)
    );

    seq_multiplier #(.WIDTH(W), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .p(p_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int cycles);
        start = s;
        a     = av;
        b     = bv;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Protocol model: acceptance in IDLE/DONE, start ignored in RUN, DONE after exactly W RUN cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            held_u  = '0;
            held_s  = '0;
            sb.delete();
        end else begin
            case (m_state)
                M_RUN: begin
                    if (m_cnt == W - 1) m_state = M_DONE;
                    else m_cnt++;
                end
                default: begin
                    if (start) begin
                        exp_t e;
                        logic signed [2*W-1:0] sa, sbv;
                        sa  = $signed(a);
                        sbv = $signed(b);
                        e.pu = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                        e.ps = sa * sbv;
                        sb.push_back(e);
                        m_state = M_RUN;
                        m_cnt   = 0;
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_state == M_DONE) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL sb_pending at %0t: got no queued product, expected one", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    held_u = e.pu;
                    held_s = e.ps;
                end
            end
            checkOutput("busy_u", 16'(busy_u), 16'(m_state == M_RUN));
            checkOutput("done_u", 16'(done_u), 16'(m_state == M_DONE));
            checkOutput("p_u",    16'(p_u),    16'(held_u));
            checkOutput("busy_s", 16'(busy_s), 16'(m_state == M_RUN));
            checkOutput("done_s", 16'(done_s), 16'(m_state == M_DONE));
            checkOutput("p_s",    16'(p_s),    16'(held_s));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        #3;
        checkOutput("rst_busy_u", 16'(busy_u), 16'h0);
        checkOutput("rst_done_u", 16'(done_u), 16'h0);
        checkOutput("rst_p_u",    16'(p_u),    16'h0);
        checkOutput("rst_busy_s", 16'(busy_s), 16'h0);
        checkOutput("rst_done_s", 16'(done_s), 16'h0);
        checkOutput("rst_p_s",    16'(p_s),    16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] unsigned maximum and signed corners");
        applyStimulus(1'b1, 4'd15, 4'd15, 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 6);
        checkOutput("max_u", 16'(p_u), 16'h00E1);
        applyStimulus(1'b1, 4'b1000, 4'b1000, 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 6);
        checkOutput("neg8sq_s", 16'(p_s), 16'h0040);
        applyStimulus(1'b1, 4'b1000, 4'd7, 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 6);
        checkOutput("neg8x7_s", 16'(p_s), 16'h00C8);

        $display("[TB] start while busy");
        applyStimulus(1'b1, 4'd3, 4'd5, 1);
        applyStimulus(1'b0, 4'd3, 4'd5, 1);
        applyStimulus(1'b1, 4'd9, 4'd9, 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 8);
        checkOutput("busy_ignore_u", 16'(p_u), 16'd15);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 4'd6, 4'd7, 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 2);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy_u", 16'(busy_u), 16'h0);
        checkOutput("abort_done_u", 16'(done_u), 16'h0);
        checkOutput("abort_p_u",    16'(p_u),    16'h0);
        checkOutput("abort_p_s",    16'(p_s),    16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 4);
        applyStimulus(1'b1, 4'd5, 4'd5, 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 6);
        checkOutput("after_reset_u", 16'(p_u), 16'd25);

        $display("[TB] back-to-back with start held");
        applyStimulus(1'b1, 4'd2, 4'd3, 5);
        applyStimulus(1'b1, 4'd0, 4'd7, 1);
        checkOutput("b2b_first_u", 16'(p_u), 16'd6);
        applyStimulus(1'b0, 4'd0, 4'd0, 7);
        checkOutput("b2b_second_u", 16'(p_u), 16'd0);

        $display("[TB] exhaustive operand sweep");
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus(1'b1, 4'(i), 4'(j), 1);
                applyStimulus(1'b0, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4);
            end
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 8);
        checkOutput("sb_drained", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
